// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and pipe_hazard_ctrl (slave).
// Optional macro HAZARD_STALL_CNT_EN adds the stall_count signal and its CNT_W width.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              ex_mem_write;
  logic              mem_wb_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_count;
`endif

  // Datapath side: supplies stage status, consumes pipeline controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_bubble
`ifdef HAZARD_STALL_CNT_EN
    , input stall_count
`endif
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_bubble
`ifdef HAZARD_STALL_CNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline write-enable / flush / bubble sequencer.
// Handles load-use stalls, data-memory freezes and branch flushes (including
// flushes that arrive while frozen, which are deferred until the wait ends).
// Optional macro HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic       FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  state_t            state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic              flush_pend_q, flush_pend_d;

  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              freeze, load_use, branch;
  logic              pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic              if_id_flush, id_ex_bubble;

  assign id_rs1 = hz.id_rs1;
  assign id_rs2 = hz.id_rs2;
  assign ex_rd  = hz.ex_rd;
  assign branch = hz.ex_branch_taken;
  assign freeze = hz.mem_req & ~hz.mem_ready;

  // A load in EX whose destination (never x0) feeds a source of the ID instruction
  assign load_use = hz.ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (hz.id_uses_rs2 && (ex_rd == id_rs2)));

  // Register state, flush countdown and deferred-flush flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_cnt_q  <= 3'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state and control outputs; a memory freeze overrides everything,
  // then a branch flush, then a load-use stall
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    if (freeze) begin
      state_d = MEM_WAIT;
      if (branch) flush_pend_d = 1'b1;
    end else begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      unique case (state_q)
        MEM_WAIT: begin
          if (branch) flush_pend_d = 1'b1;
          if (flush_pend_q || branch || (flush_cnt_q != 3'd0)) state_d = FLUSH;
          else                                                 state_d = RUN;
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          if (branch || flush_pend_q) begin
            id_ex_bubble = 1'b1;
            flush_cnt_d  = FLUSH_RELOAD;
            flush_pend_d = 1'b0;
            state_d      = FLUSH_MULTI ? FLUSH : RUN;
          end else begin
            if (flush_cnt_q != 3'd0) flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) state_d = RUN;
          end
        end
        default: begin
          if (branch) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_cnt_d  = FLUSH_RELOAD;
            state_d      = FLUSH_MULTI ? FLUSH : RUN;
          end else if (load_use) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  assign hz.pc_write     = rst_n & pc_we;
  assign hz.if_id_write  = rst_n & if_id_we;
  assign hz.id_ex_write  = rst_n & id_ex_we;
  assign hz.ex_mem_write = rst_n & ex_mem_we;
  assign hz.mem_wb_write = rst_n & mem_wb_we;
  assign hz.if_id_flush  = rst_n & if_id_flush;
  assign hz.id_ex_bubble = rst_n & id_ex_bubble;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count every cycle the PC is held, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_cnt_q <= '0;
    else if (!pc_we && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign hz.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with FLUSH_CYCLES=2.
// Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_ZERO   = 7'b00000_00;
  localparam logic [6:0] C_IDLE   = 7'b11111_00;
  localparam logic [6:0] C_FREEZE = 7'b00000_00;
  localparam logic [6:0] C_LDUSE  = 7'b00111_01;
  localparam logic [6:0] C_BRANCH = 7'b11111_11;
  localparam logic [6:0] C_FLUSH  = 7'b11111_10;
  localparam logic [6:0] M_NOBUB  = 7'b11111_10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [6:0] obs;

  pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl();
    return {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
            hz.mem_wb_write, hz.if_id_flush, hz.id_ex_bubble};
  endfunction

  task automatic set_idle();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs2 = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    #2;
    obs = ctrl(); n_checks++;
    if (obs !== C_ZERO) begin n_fail++; $display("[TB] FAIL reset_hold: got %b want %b", obs, C_ZERO); end
    next_cycle(); rst_n = 1'b1;
    @(negedge clk); obs = ctrl(); n_checks++;
    if (obs !== C_IDLE) begin n_fail++; $display("[TB] FAIL reset_release: got %b want %b", obs, C_IDLE); end
    next_cycle();
    hz.mem_req = 1'b1; hz.ex_branch_taken = 1'b1;
    next_cycle();
    set_idle(); rst_n = 1'b0; #2;
    obs = ctrl(); n_checks++;
    if (obs !== C_ZERO) begin n_fail++; $display("[TB] FAIL reset_mid_wait: got %b want %b", obs, C_ZERO); end
    next_cycle(); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== C_IDLE) begin n_fail++; $display("[TB] FAIL reset_discard_%0d: got %b want %b", i, obs, C_IDLE); end
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    logic [4:0] rd_t  [6] = '{5'd5, 5'd5, 5'd7, 5'd7, 5'd0, 5'd9};
    logic [4:0] rs1_t [6] = '{5'd5, 5'd3, 5'd1, 5'd1, 5'd0, 5'd9};
    logic [4:0] rs2_t [6] = '{5'd0, 5'd5, 5'd7, 5'd7, 5'd0, 5'd2};
    logic       u2_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       ld_t  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0] exp_t [6] = '{C_LDUSE, C_LDUSE, C_LDUSE, C_IDLE, C_IDLE, C_IDLE};
    for (int i = 0; i < 6; i++) begin
      set_idle();
      hz.ex_rd = rd_t[i]; hz.id_rs1 = rs1_t[i]; hz.id_rs2 = rs2_t[i];
      hz.id_uses_rs2 = u2_t[i]; hz.ex_mem_read = ld_t[i];
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== exp_t[i]) begin n_fail++; $display("[TB] FAIL load_use_%0d: got %b want %b", i, obs, exp_t[i]); end
      next_cycle();
      set_idle();
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== C_IDLE) begin n_fail++; $display("[TB] FAIL load_use_after_%0d: got %b want %b", i, obs, C_IDLE); end
      next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== C_FREEZE) begin n_fail++; $display("[TB] FAIL mem_wait_%0d: got %b want %b", i, obs, C_FREEZE); end
      next_cycle();
    end
    hz.mem_ready = 1'b1;
    @(negedge clk); obs = ctrl(); n_checks++;
    if (obs !== C_IDLE) begin n_fail++; $display("[TB] FAIL mem_ready: got %b want %b", obs, C_IDLE); end
    next_cycle();
    set_idle();
    @(negedge clk); obs = ctrl(); n_checks++;
    if (obs !== C_IDLE) begin n_fail++; $display("[TB] FAIL mem_after: got %b want %b", obs, C_IDLE); end
`ifdef HAZARD_STALL_CNT_EN
    n_checks++;
    if (hz.stall_count !== 32'd3) begin n_fail++; $display("[TB] FAIL stall_count: got %0d want 3", hz.stall_count); end
`endif
    next_cycle();
  endtask

  task automatic test_branch();
    logic [6:0] exp_t [3] = '{C_BRANCH, C_FLUSH, C_IDLE};
    for (int i = 0; i < 3; i++) begin
      set_idle(); hz.ex_branch_taken = (i == 0);
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== exp_t[i]) begin n_fail++; $display("[TB] FAIL branch_%0d: got %b want %b", i, obs, exp_t[i]); end
      next_cycle();
    end
  endtask

  task automatic test_branch_during_wait();
    set_idle(); hz.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hz.ex_branch_taken = (i == 1);
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== C_FREEZE) begin n_fail++; $display("[TB] FAIL bwait_freeze_%0d: got %b want %b", i, obs, C_FREEZE); end
      next_cycle();
    end
    hz.ex_branch_taken = 1'b0; hz.mem_ready = 1'b1;
    @(negedge clk); obs = ctrl(); n_checks++;
    if (obs !== C_IDLE) begin n_fail++; $display("[TB] FAIL bwait_ready: got %b want %b", obs, C_IDLE); end
    next_cycle();
    set_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); obs = ctrl() & M_NOBUB; n_checks++;
      if (obs !== M_NOBUB) begin n_fail++; $display("[TB] FAIL bwait_flush_%0d: got %b want %b", i, obs, M_NOBUB); end
      next_cycle();
    end
    @(negedge clk); obs = ctrl(); n_checks++;
    if (obs !== C_IDLE) begin n_fail++; $display("[TB] FAIL bwait_done: got %b want %b", obs, C_IDLE); end
    next_cycle();
  endtask

  task automatic test_branch_load_use();
    logic [6:0] exp_t [4] = '{C_BRANCH, C_FLUSH, C_IDLE, C_LDUSE};
    for (int i = 0; i < 4; i++) begin
      set_idle();
      hz.ex_branch_taken = (i == 0);
      hz.ex_mem_read = (i != 2); hz.ex_rd = 5'd6; hz.id_rs1 = 5'd6;
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== exp_t[i]) begin n_fail++; $display("[TB] FAIL branch_ldu_%0d: got %b want %b", i, obs, exp_t[i]); end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic       br_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [6:0] exp_t [4] = '{C_BRANCH, C_BRANCH, C_FLUSH, C_IDLE};
    for (int i = 0; i < 4; i++) begin
      set_idle(); hz.ex_branch_taken = br_t[i];
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== exp_t[i]) begin n_fail++; $display("[TB] FAIL back_to_back_%0d: got %b want %b", i, obs, exp_t[i]); end
      next_cycle();
    end
  endtask

  task automatic test_freeze_in_flush();
    logic       br_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       req_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rdy_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [6:0] exp_t [5] = '{C_BRANCH, C_FREEZE, C_IDLE, C_FLUSH, C_IDLE};
    for (int i = 0; i < 5; i++) begin
      set_idle();
      hz.ex_branch_taken = br_t[i]; hz.mem_req = req_t[i]; hz.mem_ready = rdy_t[i];
      @(negedge clk); obs = ctrl(); n_checks++;
      if (obs !== exp_t[i]) begin n_fail++; $display("[TB] FAIL freeze_in_flush_%0d: got %b want %b", i, obs, exp_t[i]); end
      next_cycle();
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_branch_during_wait();
    test_branch_load_use();
    test_back_to_back();
    test_freeze_in_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
